// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: operation encodings.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_BRANCH = 3'b010,
    OP_JUMP   = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_RSVD6  = 3'b110,
    OP_RSVD7  = 3'b111
  } pc_op_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO: one push or pop per cycle, push ignored when full,
// pop ignored when empty. Only the depth counter is reset.
module ras_stack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic [DATA_W-1:0]  top_o,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push_ok, pop_ok;

  assign full_o  = (depth_q == DEPTH_W'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !push_i && !empty_o;

  // Depth is a power of two, so the low pointer bits wrap exactly onto the array.
  assign wr_ptr  = depth_q[PTR_W-1:0];
  assign rd_ptr  = wr_ptr - PTR_W'(1);
  assign top_o   = mem_q[rd_ptr];
  assign depth_o = depth_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    depth_d = depth_q;
    if (push_ok)     depth_d = depth_q + DEPTH_W'(1);
    else if (pop_ok) depth_d = depth_q - DEPTH_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // NOTE: storage is deliberately not reset; an entry is only read while depth > 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment, relative branch, jump, call/return
// through a return-address stack, with sticky error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8,
  parameter int INC_STEP    = 1,
  parameter int RESET_VEC   = 0,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [2:0]         pc_op,
  input  logic               cond,
  input  logic [ADDR_W-1:0]  offset,
  input  logic [ADDR_W-1:0]  target,
  input  logic               clr_err,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [DEPTH_W-1:0] ras_depth,
  output logic               ras_full,
  output logic               ras_empty,
  output logic               err_overflow,
  output logic               err_underflow,
  output logic               err_illegal
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INC_STEP);
  localparam logic [ADDR_W-1:0] VEC  = ADDR_W'(RESET_VEC);

  pc_op_e            op;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic              ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;
  logic              ovf_set, unf_set, ill_set;
  logic              push, pop;

  assign op     = pc_op_e'(pc_op);
  assign pc_inc = pc_q + STEP;

  ras_stack #(
    .DATA_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (ras_top),
    .depth_o (ras_depth),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    ill_set = 1'b0;
    if (!stall) begin
      case (op)
        OP_HOLD:   pc_d = pc_q;
        OP_INC:    pc_d = pc_inc;
        OP_BRANCH: pc_d = cond ? (pc_q + offset) : pc_inc;
        OP_JUMP:   pc_d = target;
        // A call always redirects; only the return address is lost when full.
        OP_CALL: begin
          pc_d = target;
          if (ras_full) ovf_set = 1'b1;
          else          push    = 1'b1;
        end
        OP_RET: begin
          if (ras_empty) begin
            unf_set = 1'b1;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end
        default:   ill_set = 1'b1;
      endcase
    end
  end

  // Setting a flag wins over a same-cycle clear; stall freezes both.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    ill_d = ill_q;
    if (!stall) begin
      ovf_d = ovf_set | (ovf_q & ~clr_err);
      unf_d = unf_set | (unf_q & ~clr_err);
      ill_d = ill_set | (ill_q & ~clr_err);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      ill_q <= ill_d;
    end
  end

  assign pc_out        = pc_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign err_illegal   = ill_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table plus hand-written
// overflow/underflow, stall and mid-cycle reset sequences.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int AW = 16;
  localparam int SD = 8;
  localparam int DW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          stall, cond, clr_err;
  logic [2:0]    pc_op;
  logic [AW-1:0] offset, target;

  logic [AW-1:0] pc_out, pc_out2;
  logic [DW-1:0] ras_depth, ras_depth2;
  logic          ras_full, ras_empty, err_overflow, err_underflow, err_illegal;
  logic          ras_full2, ras_empty2, err_overflow2, err_underflow2, err_illegal2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .INC_STEP(1), .RESET_VEC(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .cond(cond),
    .offset(offset), .target(target), .clr_err(clr_err),
    .pc_out(pc_out), .ras_depth(ras_depth), .ras_full(ras_full), .ras_empty(ras_empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_illegal(err_illegal)
  );

  pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .INC_STEP(2), .RESET_VEC(0)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .cond(cond),
    .offset(offset), .target(target), .clr_err(clr_err),
    .pc_out(pc_out2), .ras_depth(ras_depth2), .ras_full(ras_full2), .ras_empty(ras_empty2),
    .err_overflow(err_overflow2), .err_underflow(err_underflow2), .err_illegal(err_illegal2)
  );

  typedef struct {
    logic [2:0]    op;
    logic          cond;
    logic [AW-1:0] offset;
    logic [AW-1:0] target;
    logic          clr;
    logic          stall;
    logic [AW-1:0] pc;
    logic [DW-1:0] depth;
    logic [2:0]    err;   // {overflow, underflow, illegal}
  } vec_t;

  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic c, input logic [AW-1:0] off,
                              input logic [AW-1:0] tgt, input logic clr, input logic stl,
                              input logic [AW-1:0] pc, input int depth, input logic [2:0] err);
    vec_t v;
    v.op = op; v.cond = c; v.offset = off; v.target = tgt; v.clr = clr; v.stall = stl;
    v.pc = pc; v.depth = DW'(depth); v.err = err;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    pc_op   = v.op;
    cond    = v.cond;
    offset  = v.offset;
    target  = v.target;
    clr_err = v.clr;
    stall   = v.stall;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({name, "_pc"},    32'(pc_out),    32'(e.pc));
    check({name, "_depth"}, 32'(ras_depth), 32'(e.depth));
    check({name, "_err"},   32'({err_overflow, err_underflow, err_illegal}), 32'(e.err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  vec_t          vecs[21];
  vec_t          v;
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] exp_stk[$];

  initial begin
    vecs[0]  = mk(OP_INC,    0, 16'h0000, 16'h0000, 0, 0, 16'h0001, 0, 3'b000);
    vecs[1]  = mk(OP_INC,    0, 16'h0000, 16'h0000, 0, 0, 16'h0002, 0, 3'b000);
    vecs[2]  = mk(OP_INC,    0, 16'h0000, 16'h0000, 0, 0, 16'h0003, 0, 3'b000);
    vecs[3]  = mk(OP_JUMP,   0, 16'h0000, 16'h0010, 0, 0, 16'h0010, 0, 3'b000);
    vecs[4]  = mk(OP_BRANCH, 1, 16'hFFF8, 16'h0000, 0, 0, 16'h0008, 0, 3'b000);
    vecs[5]  = mk(OP_JUMP,   0, 16'h0000, 16'h0010, 0, 0, 16'h0010, 0, 3'b000);
    vecs[6]  = mk(OP_BRANCH, 0, 16'hFFF8, 16'h0000, 0, 0, 16'h0011, 0, 3'b000);
    vecs[7]  = mk(OP_JUMP,   0, 16'h0000, 16'hFFFF, 0, 0, 16'hFFFF, 0, 3'b000);
    vecs[8]  = mk(OP_INC,    0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 3'b000);
    vecs[9]  = mk(OP_JUMP,   0, 16'h0000, 16'h0020, 0, 0, 16'h0020, 0, 3'b000);
    vecs[10] = mk(OP_CALL,   0, 16'h0000, 16'h0100, 0, 0, 16'h0100, 1, 3'b000);
    vecs[11] = mk(OP_INC,    0, 16'h0000, 16'h0000, 0, 0, 16'h0101, 1, 3'b000);
    vecs[12] = mk(OP_CALL,   0, 16'h0000, 16'h0200, 0, 0, 16'h0200, 2, 3'b000);
    vecs[13] = mk(OP_RET,    0, 16'h0000, 16'h0000, 0, 0, 16'h0102, 1, 3'b000);
    vecs[14] = mk(OP_RET,    0, 16'h0000, 16'h0000, 0, 0, 16'h0021, 0, 3'b000);
    vecs[15] = mk(OP_HOLD,   0, 16'h0000, 16'h0000, 0, 0, 16'h0021, 0, 3'b000);
    vecs[16] = mk(3'b110,    0, 16'h0000, 16'h0000, 0, 0, 16'h0021, 0, 3'b001);
    vecs[17] = mk(OP_INC,    0, 16'h0000, 16'h0000, 1, 0, 16'h0022, 0, 3'b000);
    vecs[18] = mk(3'b111,    0, 16'h0000, 16'h0000, 1, 0, 16'h0022, 0, 3'b001);
    vecs[19] = mk(OP_HOLD,   0, 16'h0000, 16'h0000, 1, 1, 16'h0022, 0, 3'b001);
    vecs[20] = mk(OP_HOLD,   0, 16'h0000, 16'h0000, 1, 0, 16'h0022, 0, 3'b000);

    reset = 1'b1; stall = 1'b0; cond = 1'b0; clr_err = 1'b0;
    pc_op = OP_HOLD; offset = '0; target = '0;
    #12;
    check("reset_pc",    32'(pc_out), 32'h0);
    check("reset_depth", 32'(ras_depth), 32'h0);
    check("reset_err",   32'({err_overflow, err_underflow, err_illegal}), 32'h0);
    check("reset_empty", 32'(ras_empty), 32'h1);
    check("reset_full",  32'(ras_full), 32'h0);
    check("reset_pc2",   32'(pc_out2), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
      if (i < 3) check($sformatf("inc2_%0d", i), 32'(pc_out2), 32'(2 * (i + 1)));
    end

    // Nine calls into an eight-deep stack, then nine returns.
    exp_pc = 16'h0022;
    for (int k = 0; k < 9; k++) begin
      logic [AW-1:0] tgt;
      tgt = 16'h1000 + AW'(k * 16);
      if (exp_stk.size() < SD) exp_stk.push_back(exp_pc + 16'h0001);
      exp_pc = tgt;
      v = mk(OP_CALL, 0, '0, tgt, 0, 0, exp_pc, exp_stk.size(), (k == 8) ? 3'b100 : 3'b000);
      apply(v, $sformatf("call%0d", k));
      check($sformatf("call%0d_full", k), 32'(ras_full), (k >= 7) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 9; k++) begin
      logic [2:0] e;
      e = 3'b100;
      if (exp_stk.size() > 0) exp_pc = exp_stk.pop_back();
      else                    e = 3'b110;
      v = mk(OP_RET, 0, '0, '0, 0, 0, exp_pc, exp_stk.size(), e);
      apply(v, $sformatf("ret%0d", k));
      check($sformatf("ret%0d_empty", k), 32'(ras_empty), (k >= 7) ? 32'h1 : 32'h0);
    end
    apply(mk(OP_HOLD, 0, '0, '0, 1, 0, 16'h0023, 0, 3'b000), "clr_all");

    // A call held off by three stall cycles, then released.
    for (int k = 0; k < 3; k++)
      apply(mk(OP_CALL, 0, '0, 16'h0300, 0, 1, 16'h0023, 0, 3'b000), $sformatf("stall%0d", k));
    apply(mk(OP_CALL, 0, '0, 16'h0300, 0, 0, 16'h0300, 1, 3'b000), "stall_release");

    // Reset pulse between clock edges while a call is presented.
    @(negedge clk);
    pc_op = OP_CALL; target = 16'h0400; stall = 1'b0; clr_err = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_pc",    32'(pc_out), 32'h0);
    check("midrst_depth", 32'(ras_depth), 32'h0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_pc",    32'(pc_out), 32'h0400);
    check("postrst_depth", 32'(ras_depth), 32'h1);
    apply(mk(OP_RET, 0, '0, '0, 0, 0, 16'h0001, 0, 3'b000), "postrst_ret");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
